cnt_checker: RTL and testbench
==============================

# cnt_checker

Receive-side companion to the free-running `counter` block. It samples a `WIDTH`-bit count stream and locks once it sees `LOCK_CNT` consecutive +1 (mod 2^WIDTH) steps. While locked, it flags sequence errors, wrap-arounds and upstream restarts to zero. It sits next to any `counter` instance, in RTL or in a bench, as a self-checking monitor for the count output.

## Interface
Parameters:
- `WIDTH`, 3: width of the monitored count.
- `LOCK_CNT`, 4: consecutive good steps required to lock. Legal range 1..255.
- `ERR_W`, 8: width of the saturating error counter.

Ports:
- `clk_i`  input  1  clock; all state updates on the rising edge.
- `rst_ni`  input  1  reset; asynchronous, active-low.
- `en_i`  input  1  sample enable; `cnt_i` is evaluated only when high.
- `cnt_i`  input  WIDTH  count value under check.
- `locked_o`  output  1  high while in LOCKED.
- `err_o`  output  1  one-cycle pulse on a sequence error while locked.
- `wrap_o`  output  1  one-cycle pulse on a legal max→0 step while locked.
- `restart_o`  output  1  one-cycle pulse when the stream restarts at 0 while locked.
- `err_cnt_o`  output  ERR_W  saturating count of `err_o` pulses.

## Operation
- Internal registers:
  - `prev_q` [WIDTH]: last sample.
  - `good_q` [8]: good-step count.
  - `state_q`: one of EMPTY, ACQ, LOCKED.
- `match` = (`cnt_i` == `prev_q` + 1, truncated to WIDTH bits). Wrap from 2^WIDTH−1 to 0 is a match.
- `en_i` = 0: no register changes except the pulses, which clear to 0.
- EMPTY, `en_i` = 1: `prev_q` ← `cnt_i`, `good_q` ← 0, go to ACQ. No pulses.
- ACQ, `en_i` = 1:
  - `prev_q` ← `cnt_i`.
  - If `match`: `good_q` ← `good_q` + 1. If `good_q` + 1 == `LOCK_CNT`, go to LOCKED.
  - Otherwise `good_q` ← 0 and stay in ACQ. Repeated values count as non-match.
  - Never raises `err_o`.
- LOCKED, `en_i` = 1: `prev_q` ← `cnt_i`, then exactly one of:
  - `match`: stay. If `prev_q` == 2^WIDTH−1, pulse `wrap_o`.
  - `!match` and `cnt_i` == 0: pulse `restart_o`, `good_q` ← 0, go to ACQ. Not an error; `err_cnt_o` unchanged.
  - Any other mismatch, including a repeated value: pulse `err_o`, `err_cnt_o` ← min(`err_cnt_o` + 1, 2^ERR_W−1), `good_q` ← 0, go to ACQ.
- `err_o`, `wrap_o` and `restart_o` are mutually exclusive in any cycle.
- `err_cnt_o` is cleared only by reset.

## Timing
- All outputs are registered. The response to a sample taken at rising edge N is visible just after edge N and held until edge N+1.
- `locked_o` is `state_q` == LOCKED. It rises after the edge that takes the `LOCK_CNT`-th good step, which is the (`LOCK_CNT`+1)-th enabled sample after EMPTY.
- `locked_o` falls after the same edge that pulses `err_o` or `restart_o`.
- Pulses last exactly one cycle, including on back-to-back enabled samples.
- Reset (`rst_ni` low): immediate and independent of the clock. All outputs go to 0, `state_q` = EMPTY, `prev_q` = 0, `good_q` = 0.
- Release of `rst_ni` is taken synchronously at the next rising edge. The first enabled sample after reset only loads `prev_q`.
- Asserting reset mid-LOCKED drops all outputs within the same cycle. No pulse is emitted for the interrupted sample.

## Test plan
All scenarios use WIDTH=3 and LOCK_CNT=4 unless noted.
- **Lock and wrap:** after reset, drive 0,1,...,7,0,1 with `en_i`=1 → `locked_o` rises after the sample "4" edge; `wrap_o` pulses once at 7→0; `err_o` never fires; `err_cnt_o` stays 0.
- **Upstream reset:** lock, then drive 5,0,0,0,1,2,3,4 → `restart_o` pulses once at 5→0 and `locked_o` drops. `locked_o` returns after the sample "4" edge; `err_cnt_o` stays 0.
- **Skip error:** lock, then drive 3,5 → `err_o` pulses one cycle at 5, `err_cnt_o` goes 0→1, `locked_o` drops. `locked_o` returns after 6,7,0,1.
- **Enable gating:** lock, set `en_i`=0 and drive random values for 5 cycles, then resume the correct next value → no pulses, `locked_o` stays 1 throughout.
- **Saturation (ERR_W=2):** cause 5 lock/skip-error cycles → `err_cnt_o` reads 1,2,3,3,3 and `err_o` still pulses each time.
- **Async reset:** while locked, pull `rst_ni` low between clock edges → `locked_o` and `err_cnt_o` go 0 before the next edge. After release, the first enabled sample produces no pulse.

Source files
------------

// File: rtl/cnt_checker.sv
// Receive-side monitor for a free-running count stream: locks after LOCK_CNT
// consecutive +1 steps, then flags sequence errors, wrap-arounds and restarts.
module cnt_checker #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] cnt_i,
  output logic             locked_o,
  output logic             err_o,
  output logic             wrap_o,
  output logic             restart_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [7:0]       LOCK_TGT = 8'(LOCK_CNT);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [7:0]       good_q, good_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_q, err_d;
  logic             wrap_q, wrap_d;
  logic             restart_q, restart_d;

  logic [WIDTH-1:0] prev_inc;
  logic [7:0]       good_inc;
  logic             match;

  // Increment truncates to WIDTH bits, so max -> 0 counts as a good step.
  assign prev_inc = prev_q + WIDTH'(1);
  assign good_inc = good_q + 8'd1;
  assign match    = (cnt_i == prev_inc);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    good_d    = good_q;
    err_cnt_d = err_cnt_q;
    err_d     = 1'b0;
    wrap_d    = 1'b0;
    restart_d = 1'b0;

    if (en_i) begin
      prev_d = cnt_i;
      unique case (state_q)
        EMPTY: begin
          good_d  = '0;
          state_d = ACQ;
        end
        ACQ: begin
          if (match) begin
            good_d = good_inc;
            if (good_inc == LOCK_TGT) begin
              state_d = LOCKED;
            end
          end else begin
            good_d = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            wrap_d = (prev_q == CNT_MAX);
          end else if (cnt_i == '0) begin
            // Upstream counter was reset: re-acquire without counting an error.
            restart_d = 1'b1;
            good_d    = '0;
            state_d   = ACQ;
          end else begin
            err_d   = 1'b1;
            good_d  = '0;
            state_d = ACQ;
            if (err_cnt_q != ERR_MAX) begin
              err_cnt_d = err_cnt_q + ERR_W'(1);
            end
          end
        end
        default: begin
          state_d = EMPTY;
          good_d  = '0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= EMPTY;
      prev_q    <= '0;
      good_q    <= '0;
      err_cnt_q <= '0;
      err_q     <= 1'b0;
      wrap_q    <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      good_q    <= good_d;
      err_cnt_q <= err_cnt_d;
      err_q     <= err_d;
      wrap_q    <= wrap_d;
      restart_q <= restart_d;
    end
  end

  assign locked_o  = (state_q == LOCKED);
  assign err_o     = err_q;
  assign wrap_o    = wrap_q;
  assign restart_o = restart_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_cnt_checker.sv
// Scoreboard bench for cnt_checker: two instances (ERR_W=8 and ERR_W=2) share
// one directed stream; expected responses are queued and checked by a monitor.
module tb_cnt_checker;

  localparam int WIDTH = 3;

  typedef struct {
    int   idx;
    logic locked;
    logic err;
    logic wrap;
    logic restart;
    int   ec;
  } exp_t;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             en_i = 1'b0;
  logic [WIDTH-1:0] cnt_i = '0;

  logic       locked8, err8, wrap8, restart8;
  logic [7:0] ec8;
  logic       locked2, err2, wrap2, restart2;
  logic [1:0] ec2;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   n_steps = 0;

  always #5 clk_i = ~clk_i;

  cnt_checker #(.WIDTH(WIDTH), .LOCK_CNT(4), .ERR_W(8)) dut8 (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .cnt_i(cnt_i),
    .locked_o(locked8), .err_o(err8), .wrap_o(wrap8), .restart_o(restart8),
    .err_cnt_o(ec8)
  );

  cnt_checker #(.WIDTH(WIDTH), .LOCK_CNT(4), .ERR_W(2)) dut2 (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .cnt_i(cnt_i),
    .locked_o(locked2), .err_o(err2), .wrap_o(wrap2), .restart_o(restart2),
    .err_cnt_o(ec2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one sample at the falling edge and queue the hand-computed response.
  task automatic step(input logic en, input int cnt, input logic l, input logic e,
                      input logic w, input logic r, input int ec);
    exp_t x;
    @(negedge clk_i);
    en_i = en;
    cnt_i = WIDTH'(cnt);
    x.idx = n_steps;
    x.locked = l;
    x.err = e;
    x.wrap = w;
    x.restart = r;
    x.ec = ec;
    exp_q.push_back(x);
    n_steps++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " locked8"}, 32'(locked8), 0);
    check({tag, " err8"}, 32'(err8), 0);
    check({tag, " wrap8"}, 32'(wrap8), 0);
    check({tag, " restart8"}, 32'(restart8), 0);
    check({tag, " ec8"}, 32'(ec8), 0);
    check({tag, " locked2"}, 32'(locked2), 0);
    check({tag, " ec2"}, 32'(ec2), 0);
  endtask

  // Monitor: outputs are registered, so each queued sample is compared 1ns
  // after the edge that consumed it.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check($sformatf("s%0d locked8", x.idx), 32'(locked8), 32'(x.locked));
        check($sformatf("s%0d err8", x.idx), 32'(err8), 32'(x.err));
        check($sformatf("s%0d wrap8", x.idx), 32'(wrap8), 32'(x.wrap));
        check($sformatf("s%0d restart8", x.idx), 32'(restart8), 32'(x.restart));
        check($sformatf("s%0d ec8", x.idx), 32'(ec8), 32'(x.ec));
        check($sformatf("s%0d locked2", x.idx), 32'(locked2), 32'(x.locked));
        check($sformatf("s%0d err2", x.idx), 32'(err2), 32'(x.err));
        check($sformatf("s%0d wrap2", x.idx), 32'(wrap2), 32'(x.wrap));
        check($sformatf("s%0d restart2", x.idx), 32'(restart2), 32'(x.restart));
        check($sformatf("s%0d ec2", x.idx), 32'(ec2), (x.ec > 3) ? 32'd3 : 32'(x.ec));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d samples pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cycles;

    repeat (2) @(posedge clk_i);
    #1;
    check_all_zero("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Lock and wrap: lock after the "4" sample, one wrap at 7->0.
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0, 0);
    step(1, 3, 0, 0, 0, 0, 0);
    step(1, 4, 1, 0, 0, 0, 0);
    step(1, 5, 1, 0, 0, 0, 0);
    step(1, 6, 1, 0, 0, 0, 0);
    step(1, 7, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0);

    // Upstream reset at 5->0; repeated zeros in ACQ are non-matches.
    step(1, 2, 1, 0, 0, 0, 0);
    step(1, 3, 1, 0, 0, 0, 0);
    step(1, 4, 1, 0, 0, 0, 0);
    step(1, 5, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0, 0);
    step(1, 3, 0, 0, 0, 0, 0);
    step(1, 4, 1, 0, 0, 0, 0);

    // Skip error 3->5, then relock on 6,7,0,1 (no wrap pulse while acquiring).
    step(1, 5, 1, 0, 0, 0, 0);
    step(1, 6, 1, 0, 0, 0, 0);
    step(1, 7, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0);
    step(1, 2, 1, 0, 0, 0, 0);
    step(1, 3, 1, 0, 0, 0, 0);
    step(1, 5, 0, 1, 0, 0, 1);
    step(1, 6, 0, 0, 0, 0, 1);
    step(1, 7, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 1, 1, 0, 0, 0, 1);

    // Enable gating: garbage (including 0) with en low changes nothing.
    step(0, 6, 1, 0, 0, 0, 1);
    step(0, 3, 1, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0, 1);
    step(0, 7, 1, 0, 0, 0, 1);
    step(0, 5, 1, 0, 0, 0, 1);
    step(1, 2, 1, 0, 0, 0, 1);
    step(1, 3, 1, 0, 0, 0, 1);

    // Async reset between edges while locked, held across one enabled edge.
    @(negedge clk_i);
    en_i = 1'b1;
    cnt_i = WIDTH'(4);
    #2;
    rst_ni = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk_i);
    #1;
    check_all_zero("rst_held");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // First enabled sample after reset only loads prev, even when it is 0.
    step(1, 0, 0, 0, 0, 0, 0);

    // Saturation: five skip errors, each followed by a relock, then a repeat.
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0, 0);
    step(1, 3, 0, 0, 0, 0, 0);
    step(1, 4, 1, 0, 0, 0, 0);
    step(1, 6, 0, 1, 0, 0, 1);
    step(1, 7, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 1);
    step(1, 2, 1, 0, 0, 0, 1);
    step(1, 4, 0, 1, 0, 0, 2);
    step(1, 5, 0, 0, 0, 0, 2);
    step(1, 6, 0, 0, 0, 0, 2);
    step(1, 7, 0, 0, 0, 0, 2);
    step(1, 0, 1, 0, 0, 0, 2);
    step(1, 2, 0, 1, 0, 0, 3);
    step(1, 3, 0, 0, 0, 0, 3);
    step(1, 4, 0, 0, 0, 0, 3);
    step(1, 5, 0, 0, 0, 0, 3);
    step(1, 6, 1, 0, 0, 0, 3);
    step(1, 1, 0, 1, 0, 0, 4);
    step(1, 2, 0, 0, 0, 0, 4);
    step(1, 3, 0, 0, 0, 0, 4);
    step(1, 4, 0, 0, 0, 0, 4);
    step(1, 5, 1, 0, 0, 0, 4);
    step(1, 7, 0, 1, 0, 0, 5);
    step(1, 0, 0, 0, 0, 0, 5);
    step(1, 1, 0, 0, 0, 0, 5);
    step(1, 2, 0, 0, 0, 0, 5);
    step(1, 3, 1, 0, 0, 0, 5);
    step(1, 3, 0, 1, 0, 0, 6);
    step(0, 3, 0, 0, 0, 0, 6);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk_i);
      wait_cycles++;
    end
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected responses still queued, required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
